accum_zone: RTL and testbench



---
 rtl/accum_zone_if.sv | 49 ++++
 rtl/accum_zone.sv | 224 ++++++++++++++++++++++
 tb/tb_accum_zone.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_zone_if.sv
// rtl/accum_zone_if.sv - command and data interfaces of one accumulation-zone master port
interface Accum_Cmd_If #(
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int ZONE_WIDTH = 2
) (
    input logic clk,
    input logic rstn
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic                  accum_en;
    logic [NUM_BANKS-1:0]  wr_mask;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ZONE_WIDTH-1:0] wr_zone_id;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [NUM_BANKS-1:0]  rd_mask;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ZONE_WIDTH-1:0] rd_zone_id;

    modport master (
        input  clk, rstn, wr_ready, rd_ready,
        output wr_valid, accum_en, wr_mask, wr_addr, wr_zone_id,
               rd_valid, rd_mask, rd_addr, rd_zone_id
    );
    modport slave (
        input  clk, rstn, wr_valid, accum_en, wr_mask, wr_addr, wr_zone_id,
               rd_valid, rd_mask, rd_addr, rd_zone_id,
        output wr_ready, rd_ready
    );
endinterface

interface Accum_Data_If #(
    parameter int NUM_BANKS  = 4,
    parameter int DATA_WIDTH = 64
) (
    input logic clk,
    input logic rstn
);
    logic                                 wvalid;
    logic                                 wready;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] wdata;
    logic                                 rvalid;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] rdata;

    modport master (input clk, rstn, wready, rvalid, rdata, output wvalid, wdata);
    modport slave  (input clk, rstn, wvalid, wdata, output wready, rvalid, rdata);
endinterface

// File: rtl/accum_zone.sv
// rtl/accum_zone.sv - multi-master banked memory zone with masked write, lane accumulate and tagged reads
module accum_zone #(
    parameter int NUM_SLOTS  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64,
    parameter int ZONE_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    Accum_Cmd_If.slave  slave_cmd_ports  [NUM_SLOTS],
    Accum_Data_If.slave slave_data_ports [NUM_SLOTS]
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int LANES  = DATA_WIDTH / 16;
    localparam int ROWS   = 2 ** ADDR_WIDTH;
    // A misconfigured instance never handshakes rather than corrupting data.
    localparam bit CFG_OK = (FIFO_DEPTH >= 3) && (DATA_WIDTH % 16 == 0) && (ZONE_WIDTH > 0);

    typedef logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] row_t;

    logic [NUM_SLOTS-1:0]  wr_valid, wvalid, accum_en, rd_valid;
    logic [NUM_BANKS-1:0]  wr_mask [NUM_SLOTS];
    logic [NUM_BANKS-1:0]  rd_mask [NUM_SLOTS];
    logic [ADDR_WIDTH-1:0] wr_addr [NUM_SLOTS];
    logic [ADDR_WIDTH-1:0] rd_addr [NUM_SLOTS];
    row_t                  wdata   [NUM_SLOTS];

    logic [NUM_SLOTS-1:0]  wr_gnt, rd_gnt, rvalid_q;
    row_t                  rdata_q [NUM_SLOTS];
    logic                  zone_en;

    assign zone_en = CFG_OK & rstn;

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        assign wr_valid[s] = slave_cmd_ports[s].wr_valid;
        assign accum_en[s] = slave_cmd_ports[s].accum_en;
        assign wr_mask[s]  = slave_cmd_ports[s].wr_mask;
        assign wr_addr[s]  = slave_cmd_ports[s].wr_addr;
        assign rd_valid[s] = slave_cmd_ports[s].rd_valid;
        assign rd_mask[s]  = slave_cmd_ports[s].rd_mask;
        assign rd_addr[s]  = slave_cmd_ports[s].rd_addr;
        assign wvalid[s]   = slave_data_ports[s].wvalid;
        assign wdata[s]    = slave_data_ports[s].wdata;

        assign slave_cmd_ports[s].wr_ready = wr_gnt[s];
        assign slave_cmd_ports[s].rd_ready = rd_gnt[s];
        assign slave_data_ports[s].wready  = wr_gnt[s];
        assign slave_data_ports[s].rvalid  = rvalid_q[s];
        assign slave_data_ports[s].rdata   = rdata_q[s];
    end

    logic [DATA_WIDTH-1:0] mem_q [NUM_BANKS][ROWS];

    function automatic logic [DATA_WIDTH-1:0] lane_add(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            r[16*l +: 16] = a[16*l +: 16] + b[16*l +: 16];
        end
        return r;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Write stage 1: command, data and old row captured at acceptance
    logic                  s1_valid_q, s1_acc_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q;
    logic [NUM_BANKS-1:0]  s1_mask_q;
    row_t                  s1_data_q, s1_old_q, s1_new, s1_old_d;

    logic                  w_any, w_acc;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [NUM_BANKS-1:0]  w_mask;
    row_t                  w_data;

    always_comb begin
        wr_gnt = '0;
        w_any  = 1'b0;
        w_acc  = 1'b0;
        w_addr = '0;
        w_mask = '0;
        w_data = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (zone_en && !w_any && wr_valid[s] && wvalid[s]) begin
                wr_gnt[s] = 1'b1;
                w_any     = 1'b1;
                w_acc     = accum_en[s];
                w_addr    = wr_addr[s];
                w_mask    = wr_mask[s];
                w_data    = wdata[s];
            end
        end
    end

    always_comb begin
        s1_new   = '0;
        s1_old_d = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            s1_new[b] = s1_acc_q ? lane_add(s1_old_q[b], s1_data_q[b]) : s1_data_q[b];
        end
        // The row being retired this edge is not yet in mem_q; take it from stage 1.
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (s1_valid_q && s1_mask_q[b] && (s1_addr_q == w_addr)) begin
                s1_old_d[b] = s1_new[b];
            end else begin
                s1_old_d[b] = mem_q[b][w_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_acc_q   <= 1'b0;
            s1_addr_q  <= '0;
            s1_mask_q  <= '0;
            s1_data_q  <= '0;
            s1_old_q   <= '0;
        end else begin
            s1_valid_q <= w_any;
            s1_acc_q   <= w_acc;
            s1_addr_q  <= w_addr;
            s1_mask_q  <= w_mask;
            s1_data_q  <= w_data;
            s1_old_q   <= s1_old_d;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_valid_q) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (s1_mask_q[b]) begin
                    mem_q[b][s1_addr_q] <= s1_new[b];
                end
            end
        end
    end

    // Read path: arbitration, two data stages, slot tag FIFO
    logic [SLOT_W-1:0]     tag_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  fifo_full, r_any;
    logic [SLOT_W-1:0]     r_tag, tag_head;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [NUM_BANKS-1:0]  r_mask;
    logic                  p1_valid_q, p2_valid_q;
    row_t                  p1_data_q, p2_data_q, p1_data_d;

    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign tag_head  = tag_q[rd_ptr_q];

    always_comb begin
        logic seen;
        seen   = 1'b0;
        rd_gnt = '0;
        r_any  = 1'b0;
        r_tag  = '0;
        r_addr = '0;
        r_mask = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (!seen && rd_valid[s]) begin
                seen = 1'b1;
                if (zone_en && !fifo_full
                        && !(s1_valid_q && (s1_addr_q == rd_addr[s]))
                        && !(w_any && (w_addr == rd_addr[s]))) begin
                    rd_gnt[s] = 1'b1;
                    r_any     = 1'b1;
                    r_tag     = SLOT_W'(s);
                    r_addr    = rd_addr[s];
                    r_mask    = rd_mask[s];
                end
            end
        end
    end

    always_comb begin
        p1_data_d = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (r_mask[b]) begin
                p1_data_d[b] = mem_q[b][r_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p1_valid_q <= 1'b0;
            p2_valid_q <= 1'b0;
            p1_data_q  <= '0;
            p2_data_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rvalid_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) tag_q[i] <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) rdata_q[s] <= '0;
        end else begin
            p1_valid_q <= r_any;
            p1_data_q  <= p1_data_d;
            p2_valid_q <= p1_valid_q;
            p2_data_q  <= p1_data_q;
            if (r_any) begin
                tag_q[wr_ptr_q] <= r_tag;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (p2_valid_q) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(r_any) - CNT_W'(p2_valid_q);
            for (int s = 0; s < NUM_SLOTS; s++) begin
                rvalid_q[s] <= p2_valid_q && (tag_head == SLOT_W'(s));
                rdata_q[s]  <= (p2_valid_q && (tag_head == SLOT_W'(s))) ? p2_data_q : '0;
            end
        end
    end
endmodule

// File: tb/tb_accum_zone.sv
// tb/tb_accum_zone.sv - directed and random checks of accum_zone against a row-level memory model
module tb_accum_zone;
    localparam int NS = 2, FD = 4, NB = 4, AW = 9, DW = 64, ZW = 2;
    typedef logic [NB-1:0][DW-1:0] row_t;
    typedef struct {
        int   due;
        int   slot;
        row_t data;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    Accum_Cmd_If  #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .ZONE_WIDTH(ZW)) cmd_if  [NS] (.clk(clk), .rstn(rstn));
    Accum_Data_If #(.NUM_BANKS(NB), .DATA_WIDTH(DW))                  data_if [NS] (.clk(clk), .rstn(rstn));

    accum_zone #(.NUM_SLOTS(NS), .FIFO_DEPTH(FD), .NUM_BANKS(NB), .ADDR_WIDTH(AW),
                 .DATA_WIDTH(DW), .ZONE_WIDTH(ZW)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .slave_cmd_ports  (cmd_if),
        .slave_data_ports (data_if)
    );

    logic          d_wr_valid [NS], d_wvalid [NS], d_accum [NS], d_rd_valid [NS];
    logic [NB-1:0] d_wr_mask  [NS], d_rd_mask [NS];
    logic [AW-1:0] d_wr_addr  [NS], d_rd_addr [NS];
    row_t          d_wdata    [NS];
    logic [NS-1:0] o_wr_ready, o_wready, o_rd_ready, o_rvalid;
    row_t          o_rdata    [NS];

    for (genvar s = 0; s < NS; s++) begin : g_conn
        assign cmd_if[s].wr_valid   = d_wr_valid[s];
        assign cmd_if[s].accum_en   = d_accum[s];
        assign cmd_if[s].wr_mask    = d_wr_mask[s];
        assign cmd_if[s].wr_addr    = d_wr_addr[s];
        assign cmd_if[s].wr_zone_id = ZW'(s + 1);
        assign cmd_if[s].rd_valid   = d_rd_valid[s];
        assign cmd_if[s].rd_mask    = d_rd_mask[s];
        assign cmd_if[s].rd_addr    = d_rd_addr[s];
        assign cmd_if[s].rd_zone_id = ZW'(s + 2);
        assign data_if[s].wvalid    = d_wvalid[s];
        assign data_if[s].wdata     = d_wdata[s];
        assign o_wr_ready[s]        = cmd_if[s].wr_ready;
        assign o_rd_ready[s]        = cmd_if[s].rd_ready;
        assign o_wready[s]          = data_if[s].wready;
        assign o_rvalid[s]          = data_if[s].rvalid;
        assign o_rdata[s]           = data_if[s].rdata;
    end

    row_t          mdl [2**AW];
    rd_exp_t       rq [$];
    bit            pend_v;
    logic [AW-1:0] pend_a;
    int            cyc, checks, failures;
    logic [NS-1:0] last_wg, last_rg, seen_rv, seen_wrr;
    row_t          seen_rd [NS];
    int            seen_cyc;

    task automatic chk(input string tag, input logic [NB*DW-1:0] obs, input logic [NB*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] add16(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        for (int l = 0; l < DW / 16; l++) r[16*l +: 16] = 16'((a[16*l +: 16] + b[16*l +: 16]) % 65536);
        return r;
    endfunction

    function automatic row_t mk_row(input int base, input logic [NB-1:0] m);
        row_t r;
        for (int b = 0; b < NB; b++) r[b] = m[b] ? DW'(base + b) : '0;
        return r;
    endfunction

    function automatic row_t fill_row(input logic [15:0] lane);
        row_t r;
        for (int b = 0; b < NB; b++) r[b] = {DW/16{lane}};
        return r;
    endfunction

    // One clock cycle: predict handshakes and read returns, compare, then advance the model.
    task automatic tick();
        logic [NS-1:0] eg, er, erv;
        row_t          erd [NS];
        bit            w_any;
        int            ws, rs, n_fifo;
        logic [AW-1:0] wa;
        @(negedge clk);
        eg = '0; er = '0; w_any = 0; ws = 0; rs = 0; wa = '0;
        if (rstn) begin
            for (int s = 0; s < NS; s++) begin
                if (!w_any && d_wr_valid[s] && d_wvalid[s]) begin
                    eg[s] = 1'b1; w_any = 1; ws = s; wa = d_wr_addr[s];
                end
            end
            n_fifo = 0;
            foreach (rq[i]) if (rq[i].due > cyc) n_fifo++;
            for (int s = 0; s < NS; s++) begin
                if (d_rd_valid[s]) begin
                    if (n_fifo < FD && !(pend_v && pend_a == d_rd_addr[s]) && !(w_any && wa == d_rd_addr[s])) begin
                        er[s] = 1'b1; rs = s;
                    end
                    break;
                end
            end
        end
        erv = '0;
        for (int s = 0; s < NS; s++) erd[s] = '0;
        foreach (rq[i]) if (rq[i].due == cyc) begin erv[rq[i].slot] = 1'b1; erd[rq[i].slot] = rq[i].data; end
        chk("wr_ready", o_wr_ready, eg);
        chk("wready", o_wready, eg);
        chk("rd_ready", o_rd_ready, er);
        chk("rvalid", o_rvalid, erv);
        for (int s = 0; s < NS; s++) chk($sformatf("rdata_slot%0d", s), o_rdata[s], erd[s]);
        seen_rv = o_rvalid; seen_wrr = o_wr_ready; seen_cyc = cyc;
        for (int s = 0; s < NS; s++) seen_rd[s] = o_rdata[s];
        while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
        if (w_any) begin
            for (int b = 0; b < NB; b++) begin
                if (d_wr_mask[ws][b]) mdl[wa][b] = d_accum[ws] ? add16(mdl[wa][b], d_wdata[ws][b]) : d_wdata[ws][b];
            end
        end
        if (er != '0) begin
            rd_exp_t e;
            e.due = cyc + 3; e.slot = rs;
            for (int b = 0; b < NB; b++) e.data[b] = d_rd_mask[rs][b] ? mdl[d_rd_addr[rs]][b] : '0;
            rq.push_back(e);
        end
        pend_v = w_any; pend_a = wa;
        last_wg = eg; last_rg = er;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset(input bit with_req);
        d_wr_valid[0] = with_req; d_wvalid[0] = with_req; d_rd_valid[0] = with_req;
        rstn = 1'b0;
        rq.delete();
        pend_v = 0;
        #1;
        chk("rst_wr_ready", o_wr_ready, '0);
        chk("rst_rd_ready", o_rd_ready, '0);
        chk("rst_rvalid", o_rvalid, '0);
        chk("rst_rdata0", o_rdata[0], '0);
        chk("rst_rdata1", o_rdata[1], '0);
        repeat (2) tick();
        d_wr_valid[0] = 0; d_wvalid[0] = 0; d_rd_valid[0] = 0;
        rstn = 1'b1;
    endtask

    task automatic do_write(input int s, input logic [AW-1:0] a, input logic [NB-1:0] m, input bit acc, input row_t d);
        int n;
        d_wr_valid[s] = 1; d_wvalid[s] = 1; d_wr_addr[s] = a; d_wr_mask[s] = m; d_accum[s] = acc; d_wdata[s] = d;
        n = 0;
        do begin tick(); n++; end while (!last_wg[s] && n < 20);
        d_wr_valid[s] = 0; d_wvalid[s] = 0;
    endtask

    task automatic do_read(input int s, input logic [AW-1:0] a, input logic [NB-1:0] m, input row_t exp, input string tag);
        int  n, acc_cyc;
        bit  found;
        d_rd_valid[s] = 1; d_rd_addr[s] = a; d_rd_mask[s] = m;
        n = 0;
        do begin tick(); n++; end while (!last_rg[s] && n < 20);
        d_rd_valid[s] = 0;
        acc_cyc = cyc;
        found = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (seen_rv[s]) begin found = 1; break; end
        end
        chk({tag, "_returned"}, found, 1'b1);
        if (found) begin
            chk({tag, "_latency"}, seen_cyc - acc_cyc, 2);
            chk({tag, "_data"}, seen_rd[s], exp);
        end
    endtask

    initial begin
        int n, ops;
        checks = 0; failures = 0; cyc = 0; pend_v = 0; pend_a = '0;
        for (int s = 0; s < NS; s++) begin
            d_wr_valid[s] = 0; d_wvalid[s] = 0; d_accum[s] = 0; d_rd_valid[s] = 0;
            d_wr_mask[s] = '0; d_rd_mask[s] = '0; d_wr_addr[s] = '0; d_rd_addr[s] = '0; d_wdata[s] = '0;
        end

        do_reset(1'b1);

        do_write(0, 9'h10, 4'b1111, 0, mk_row('hA000, 4'b1111));
        do_read(0, 9'h10, 4'b1111, mk_row('hA000, 4'b1111), "full_mask");

        do_write(0, 9'h20, 4'b0101, 0, mk_row('hB000, 4'b1111));
        do_read(0, 9'h20, 4'b0101, mk_row('hB000, 4'b0101), "partial_mask");

        d_wr_valid[0] = 1; d_wvalid[0] = 1; d_wr_addr[0] = 9'h30; d_wr_mask[0] = 4'hF; d_accum[0] = 0; d_wdata[0] = mk_row('hC000, 4'hF);
        d_wr_valid[1] = 1; d_wvalid[1] = 1; d_wr_addr[1] = 9'h40; d_wr_mask[1] = 4'hF; d_accum[1] = 0; d_wdata[1] = mk_row('hD000, 4'hF);
        tick();
        chk("arb_both_req", seen_wrr, 2'b01);
        d_wr_valid[0] = 0; d_wvalid[0] = 0;
        tick();
        chk("arb_loser_next", seen_wrr, 2'b10);
        d_wr_valid[1] = 0; d_wvalid[1] = 0;

        d_rd_valid[0] = 1; d_rd_addr[0] = 9'h10; d_rd_mask[0] = 4'hF;
        n = 0;
        do begin tick(); n++; end while (!last_rg[0] && n < 20);
        d_rd_valid[0] = 0;
        tick();
        do_reset(1'b0);
        repeat (4) tick();

        do_write(1, 9'h50, 4'b1111, 0, mk_row('hE000, 4'b1111));
        do_read(1, 9'h50, 4'b1111, mk_row('hE000, 4'b1111), "slot1_read");
        do_read(0, 9'h10, 4'b1111, mk_row('hA000, 4'b1111), "mem_kept_over_reset");
        do_read(1, 9'h40, 4'b0011, mk_row('hD000, 4'b0011), "slot1_arb_write");

        do_write(0, 9'h60, 4'b1111, 0, fill_row(16'hFFFF));
        do_write(0, 9'h60, 4'b1111, 1, fill_row(16'h0002));
        do_read(0, 9'h60, 4'b1111, fill_row(16'h0001), "accum_wrap");
        d_wr_valid[0] = 1; d_wvalid[0] = 1; d_wr_addr[0] = 9'h60; d_wr_mask[0] = 4'hF; d_accum[0] = 1; d_wdata[0] = fill_row(16'h0001);
        repeat (3) tick();
        d_wr_valid[0] = 0; d_wvalid[0] = 0;
        do_write(1, 9'h60, 4'b1001, 1, fill_row(16'h0010));
        begin
            row_t r;
            r = fill_row(16'h0004);
            r[0] = {DW/16{16'h0014}};
            r[3] = {DW/16{16'h0014}};
            do_read(1, 9'h60, 4'b1111, r, "accum_back_to_back");
        end

        d_wr_valid[0] = 1; d_wvalid[0] = 1; d_wr_mask[0] = 4'hF; d_accum[0] = 0; d_wdata[0] = mk_row(0, 4'hF);
        for (int a = 0; a < 2**AW; a++) begin
            d_wr_addr[0] = AW'(a);
            tick();
        end
        d_wr_valid[0] = 0; d_wvalid[0] = 0;

        ops = 0; n = 0;
        while (ops < 2000 && n < 20000) begin
            for (int s = 0; s < NS; s++) begin
                if (!d_wr_valid[s] && $urandom_range(0, 1) == 1) begin
                    d_wr_valid[s] = 1;
                    d_wvalid[s]   = 1'($urandom_range(0, 1));
                    d_wr_addr[s]  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 511));
                    d_wr_mask[s]  = NB'($urandom_range(0, 15));
                    d_accum[s]    = 1'($urandom_range(0, 1));
                    for (int b = 0; b < NB; b++) d_wdata[s][b] = {$urandom, $urandom};
                end else if (d_wr_valid[s] && !d_wvalid[s]) begin
                    d_wvalid[s] = 1'($urandom_range(0, 1));
                end
                if (!d_rd_valid[s] && $urandom_range(0, 2) == 0) begin
                    d_rd_valid[s] = 1;
                    d_rd_addr[s]  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 511));
                    d_rd_mask[s]  = NB'($urandom_range(0, 15));
                end
            end
            tick();
            n++;
            for (int s = 0; s < NS; s++) begin
                if (last_wg[s]) begin d_wr_valid[s] = 0; d_wvalid[s] = 0; ops++; end
                if (last_rg[s]) begin d_rd_valid[s] = 0; ops++; end
            end
        end
        for (int s = 0; s < NS; s++) begin d_wr_valid[s] = 0; d_wvalid[s] = 0; d_rd_valid[s] = 0; end
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
